// File: rtl/pc_unit.sv
// Fetch-stage program counter with sequential/branch/jump/return selection
// and a circular return-address stack that drops its oldest entry when full.
module pc_unit #(
    parameter int PC_W      = 13,
    parameter int STEP      = 1,
    parameter int RESET_PC  = 0,
    parameter int OFFSET_W  = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  logic                jump,
    input  logic [PC_W-1:0]     jump_target,
    input  logic                call,
    input  logic                ret,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     pc_plus,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_overflow,
    output logic                ras_underflow
);
    localparam int PW    = $clog2(RAS_DEPTH);
    localparam int CW    = PW + 1;
    localparam int EXT_W = (PC_W > OFFSET_W) ? PC_W : OFFSET_W;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic            r_unf;

    logic [PC_W-1:0]  w_pc_plus;
    logic [EXT_W-1:0] w_off_ext;
    logic [PC_W-1:0]  w_br_tgt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PW-1:0]    w_top_inc;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_repl;
    logic             w_ovf;
    logic             w_unf;

    assign w_pc_plus = r_pc + PC_W'(STEP);
    assign w_off_ext = EXT_W'($signed(branch_offset));
    assign w_br_tgt  = w_pc_plus + w_off_ext[PC_W-1:0];
    assign w_top_inc = r_top + PW'(1);
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(RAS_DEPTH));

    always_comb begin
        w_pc_nxt = w_pc_plus;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_repl   = 1'b0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        if (stall) begin
            w_pc_nxt = r_pc;
        end else if (ret && !w_empty) begin
            w_pc_nxt = r_ras[r_top];
            // call+ret swaps the top entry instead of pop-then-push
            w_repl   = call;
            w_pop    = !call;
        end else begin
            w_unf  = ret;
            w_push = call;
            w_ovf  = call && w_full;
            if (ret)
                w_pc_nxt = (call && jump) ? jump_target : w_pc_plus;
            else if (jump)
                w_pc_nxt = jump_target;
            else if (branch_taken)
                w_pc_nxt = w_br_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= PC_W'(RESET_PC);
            r_top <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ovf <= w_ovf;
            r_unf <= w_unf;
            if (w_push) begin
                r_top <= w_top_inc;
                if (!w_full)
                    r_cnt <= r_cnt + CW'(1);
            end else if (w_pop) begin
                r_top <= r_top - PW'(1);
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Stack storage needs no reset: entries beyond the count are unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push)
                r_ras[w_top_inc] <= w_pc_plus;
            else if (w_repl)
                r_ras[r_top] <= w_pc_plus;
        end
    end

    assign pc            = r_pc;
    assign pc_plus       = w_pc_plus;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random control mixes,
// compared against a queue-based model of the PC and return stack.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [12:0] jump_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [12:0] pc;
    logic [12:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    int m_pc;
    int m_stack[$];
    int m_ovf;
    int m_unf;

    pc_unit #(.PC_W(13), .STEP(1), .RESET_PC(0), .OFFSET_W(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .call(call), .ret(ret), .pc(pc), .pc_plus(pc_plus), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the stack is a queue whose back is the newest entry.
    task automatic model(input bit r, s, rt, j, c, b, input logic [15:0] off,
                         input logic [12:0] jt);
        int pp;
        int npc;
        pp  = (m_pc + 1) % 8192;
        npc = pp;
        if (r) begin
            m_pc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        m_ovf = 0;
        m_unf = 0;
        if (s) return;
        if (rt && m_stack.size() > 0) begin
            if (c) begin
                npc = m_stack[m_stack.size()-1];
                m_stack[m_stack.size()-1] = pp;
            end else begin
                npc = m_stack.pop_back();
            end
        end else begin
            if (rt) m_unf = 1;
            if (c) begin
                m_stack.push_back(pp);
                if (m_stack.size() > 4) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
            end
            if (rt)          npc = (c && j) ? int'(jt) : pp;
            else if (j)      npc = int'(jt);
            else if (b)      npc = (pp + int'($signed(off))) & 8191;
        end
        m_pc = npc;
    endtask

    // Called at a negedge: drive, clock once, check at the following negedge.
    task automatic step(input string tag, input bit r, s, rt, j, c, b,
                        input logic [15:0] off, input logic [12:0] jt);
        rst = r; stall = s; ret = rt; jump = j; call = c; branch_taken = b;
        branch_offset = off; jump_target = jt;
        model(r, s, rt, j, c, b, off, jt);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".pc"},    int'(pc), m_pc);
        check({tag, ".pcp"},   int'(pc_plus), (m_pc + 1) % 8192);
        check({tag, ".empty"}, int'(ras_empty), int'(m_stack.size() == 0));
        check({tag, ".full"},  int'(ras_full), int'(m_stack.size() == 4));
        check({tag, ".ovf"},   int'(ras_overflow), m_ovf);
        check({tag, ".unf"},   int'(ras_underflow), m_unf);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 16'h0, 13'h0);
    endtask

    task automatic go(input string tag, input logic [12:0] t);
        step(tag, 0, 0, 0, 1, 0, 0, 16'h0, t);
    endtask

    initial begin
        @(negedge clk);
        // reset and free-run
        step("rst0", 1, 0, 0, 0, 0, 0, 16'h0, 13'h0);
        step("rst1", 1, 0, 0, 0, 0, 0, 16'h0, 13'h0);
        check("rst.pc_lit", int'(pc), 0);
        check("rst.empty_lit", int'(ras_empty), 1);
        idle("run1");
        idle("run2");
        idle("run3");
        check("run.pc_lit", int'(pc), 3);
        // wrap-around
        go("to1fff", 13'h1FFF);
        check("wrap.pcp_lit", int'(pc_plus), 0);
        idle("wrap");
        check("wrap.pc_lit", int'(pc), 0);
        // branch and jump-over-branch
        go("to10a", 13'd10);
        step("br-5", 0, 0, 0, 0, 0, 1, 16'hFFFB, 13'h0);
        check("br.pc_lit", int'(pc), 6);
        go("to10b", 13'd10);
        step("jmpbr", 0, 0, 0, 1, 0, 1, 16'h0007, 13'h100);
        check("jmpbr.pc_lit", int'(pc), 13'h100);
        step("brneg", 0, 0, 0, 0, 0, 1, 16'h8000, 13'h0);
        // call/return/underflow
        go("to20", 13'd20);
        step("jal40", 0, 0, 0, 1, 1, 0, 16'h0, 13'h40);
        idle("body");
        step("ret1", 0, 0, 1, 0, 0, 0, 16'h0, 13'h0);
        check("ret1.pc_lit", int'(pc), 21);
        step("ret2", 0, 0, 1, 0, 0, 0, 16'h0, 13'h0);
        check("ret2.unf_lit", int'(ras_underflow), 1);
        idle("unf_clr");
        // five calls into a four-deep stack, then four returns
        for (int i = 0; i < 5; i++)
            step($sformatf("call%0d", i), 0, 0, 0, 1, 1, 0, 16'h0, 13'(13'h200 + i * 16));
        check("ovf_lit", int'(ras_overflow), 1);
        for (int i = 0; i < 4; i++)
            step($sformatf("pop%0d", i), 0, 0, 1, 0, 0, 0, 16'h0, 13'h0);
        step("pop_empty", 0, 0, 1, 0, 0, 0, 16'h0, 13'h0);
        // stall holds everything
        step("jal_a", 0, 0, 0, 1, 1, 0, 16'h0, 13'h300);
        step("jal_b", 0, 0, 0, 1, 1, 0, 16'h0, 13'h400);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall%0d", i), 0, 1, i == 0, i == 1, 1, 1, 16'h5, 13'h77);
        step("callret", 0, 0, 1, 0, 1, 0, 16'h0, 13'h0);
        step("ret_a", 0, 0, 1, 0, 0, 0, 16'h0, 13'h0);
        step("jal_c", 0, 0, 0, 1, 1, 0, 16'h0, 13'h500);
        step("rst_mid", 1, 0, 1, 1, 1, 0, 16'h0, 13'h99);
        step("ret_after_rst", 0, 0, 1, 0, 0, 0, 16'h0, 13'h0);
        step("callret_empty", 0, 0, 1, 1, 1, 0, 16'h0, 13'h600);
        // random mixes
        for (int i = 0; i < 400; i++) begin
            bit r, s, rt, j, c, b;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 2) == 0);
            step($sformatf("rnd%0d", i), r, s, rt, j, c, b,
                 16'($urandom), 13'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
